// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding and the single next-word function
// used by both the generator and the checker.
package lfsr_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } lfsr_state_t;

   // Widest word the helper supports; callers zero-extend and keep the low WIDTH bits.
   localparam int unsigned LFSR_MAX_W = 64;

   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
      input logic [LFSR_MAX_W-1:0] s,
      input logic [LFSR_MAX_W-1:0] taps
   );
      return {s[LFSR_MAX_W-2:0], ^(s & taps)};
   endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: hunts, syncs, then flywheels the prediction
// while locked, flagging and counting mispredicted words.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 4,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     taps,
   input  logic [WIDTH-1:0]     seq,
   input  logic                 clear,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic                 lock_lost
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);

   lfsr_state_t          r_state;
   logic [WIDTH-1:0]     r_pred;
   logic [WIDTH-1:0]     r_taps_q;
   logic [MW-1:0]        r_match_cnt;
   logic [LW-1:0]        r_miss_cnt;
   logic [ERR_WIDTH-1:0] r_err_count;
   logic                 r_locked;
   logic                 r_err_pulse;
   logic                 r_lock_lost;

   logic [WIDTH-1:0]     w_seq_next;
   logic [WIDTH-1:0]     w_pred_next;
   logic [MW-1:0]        w_match_inc;
   logic [LW-1:0]        w_miss_inc;
   logic                 w_match;
   logic                 w_taps_chg;
   logic                 w_seq_zero;
   logic                 w_err_sat;

   assign w_seq_next  = WIDTH'(lfsr_next(LFSR_MAX_W'(seq), LFSR_MAX_W'(r_taps_q)));
   assign w_pred_next = WIDTH'(lfsr_next(LFSR_MAX_W'(r_pred), LFSR_MAX_W'(r_taps_q)));
   assign w_match_inc = r_match_cnt + 1'b1;
   assign w_miss_inc  = r_miss_cnt + 1'b1;
   assign w_match     = (seq == r_pred);
   assign w_taps_chg  = (taps != r_taps_q);
   assign w_seq_zero  = (seq == '0);
   assign w_err_sat   = &r_err_count;

   // NOTE: every register here, counters included, is a flop with an async reset and
   // is written only with non-blocking assignments, so the block stays latch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= HUNT;
         r_pred      <= '0;
         r_taps_q    <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
         r_err_count <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_lock_lost <= 1'b0;
      end else begin
         r_taps_q    <= taps;
         r_err_pulse <= 1'b0;
         r_lock_lost <= 1'b0;
         if (clear) begin
            r_err_count <= '0;
         end

         // A polynomial change invalidates any prediction, so it pre-empts the word.
         if (w_taps_chg) begin
            r_state     <= HUNT;
            r_locked    <= 1'b0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_lock_lost <= (r_state == LOCKED);
         end else if (enable) begin
            case (r_state)
               HUNT: begin
                  if (!w_seq_zero) begin
                     r_pred      <= w_seq_next;
                     r_match_cnt <= '0;
                     r_state     <= SYNC;
                  end
               end
               SYNC: begin
                  if (w_match) begin
                     r_match_cnt <= w_match_inc;
                     r_pred      <= w_seq_next;
                     if (w_match_inc == MW'(LOCK_COUNT)) begin
                        r_state    <= LOCKED;
                        r_locked   <= 1'b1;
                        r_miss_cnt <= '0;
                     end
                  end else if (!w_seq_zero) begin
                     r_pred      <= w_seq_next;
                     r_match_cnt <= '0;
                  end else begin
                     r_state <= HUNT;
                  end
               end
               LOCKED: begin
                  // Flywheel: the prediction never re-seeds from received data here.
                  r_pred <= w_pred_next;
                  if (w_match) begin
                     r_miss_cnt <= '0;
                  end else begin
                     r_err_pulse <= 1'b1;
                     r_miss_cnt  <= w_miss_inc;
                     if (!clear && !w_err_sat) begin
                        r_err_count <= r_err_count + 1'b1;
                     end
                     if (w_miss_inc == LW'(LOSS_COUNT)) begin
                        r_state     <= HUNT;
                        r_locked    <= 1'b0;
                        r_lock_lost <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state  <= HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;
   assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a default instance plus a 2-bit error-counter
// instance share one stimulus stream generated by a local LFSR model.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [7:0]  taps;
   logic [7:0]  seq;

   logic        locked, err_pulse, lock_lost;
   logic [15:0] err_count;
   logic        s_locked, s_err_pulse, s_lock_lost;
   logic [1:0]  s_err_count;

   typedef struct {
      logic        locked;
      logic        pulse;
      logic        lost;
      logic [15:0] err;
      logic [1:0]  sat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  gen;
   logic [15:0] exp_err = '0;
   logic [1:0]  exp_sat = '0;
   string       cur_test = "none";

   always #5 clk = ~clk;

   lfsr_checker u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .taps      (taps),
      .seq       (seq),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .lock_lost (lock_lost)
   );

   lfsr_checker #(.ERR_WIDTH(2)) u_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .taps      (taps),
      .seq       (seq),
      .clear     (clear),
      .locked    (s_locked),
      .err_pulse (s_err_pulse),
      .err_count (s_err_count),
      .lock_lost (s_lock_lost)
   );

   function automatic logic [7:0] tb_next(input logic [7:0] s, input logic [7:0] t);
      logic fb;
      fb = ^(s & t);
      return {s[6:0], fb};
   endfunction

   function automatic bit a5_soon(input logic [7:0] s, input logic [7:0] t);
      logic [7:0] v;
      v = s;
      for (int i = 0; i < 4; i++) begin
         if (v == 8'hA5) return 1'b1;
         v = tb_next(v, t);
      end
      return 1'b0;
   endfunction

   // Drives one cycle, queues its expectation, then pops and scores it after the edge.
   task automatic step(input logic [7:0] s, input logic en, input logic clr,
                       input logic e_locked, input logic e_pulse, input logic e_lost);
      exp_t e;
      exp_t got;
      seq    = s;
      enable = en;
      clear  = clr;
      if (clr) begin
         exp_err = '0;
         exp_sat = '0;
      end else if (e_pulse) begin
         if (exp_err != 16'hFFFF) exp_err = exp_err + 1'b1;
         if (exp_sat != 2'b11)    exp_sat = exp_sat + 1'b1;
      end
      e = '{e_locked, e_pulse, e_lost, exp_err, exp_sat};
      sb_q.push_back(e);
      @(posedge clk);
      #2;
      got = sb_q.pop_front();
      checks++;
      if ({locked, err_pulse, lock_lost} !== {got.locked, got.pulse, got.lost}) begin
         failures++;
         $display("FAIL %s flags locked/pulse/lost got=%b%b%b want=%b%b%b", cur_test,
                  locked, err_pulse, lock_lost, got.locked, got.pulse, got.lost);
      end
      checks++;
      if (err_count !== got.err) begin
         failures++;
         $display("FAIL %s err_count got=%0d want=%0d", cur_test, err_count, got.err);
      end
      checks++;
      if ({s_locked, s_err_pulse, s_lock_lost} !== {got.locked, got.pulse, got.lost}) begin
         failures++;
         $display("FAIL %s sat_flags got=%b%b%b want=%b%b%b", cur_test,
                  s_locked, s_err_pulse, s_lock_lost, got.locked, got.pulse, got.lost);
      end
      checks++;
      if (s_err_count !== got.sat) begin
         failures++;
         $display("FAIL %s sat_err_count got=%0d want=%0d", cur_test, s_err_count, got.sat);
      end
      enable = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic test_reset();
      cur_test = "reset";
      rst_n  = 1'b0;
      enable = 1'b0;
      clear  = 1'b0;
      taps   = 8'h00;
      seq    = 8'h00;
      #12;
      checks++;
      if ({locked, err_pulse, lock_lost, err_count, s_locked, s_err_pulse, s_lock_lost,
           s_err_count} !== '0) begin
         failures++;
         $display("FAIL reset outputs got=%b%b%b/%0d want=000/0", locked, err_pulse,
                  lock_lost, err_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_acquire();
      cur_test = "acquire";
      taps = 8'b1000_1110;
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      gen = 8'h01;
      for (int i = 0; i < 255; i++) begin
         step(gen, 1'b1, 1'b0, (i >= 4), 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
      checks++;
      if (err_count !== 16'd0) begin
         failures++;
         $display("FAIL acquire full period err_count got=%0d want=0", err_count);
      end
   endtask

   task automatic test_single_error();
      cur_test = "single_error";
      step(gen ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      gen = tb_next(gen, taps);
      for (int i = 0; i < 3; i++) begin
         step(gen, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
      checks++;
      if (err_count !== 16'd1) begin
         failures++;
         $display("FAIL single_error count got=%0d want=1", err_count);
      end
   endtask

   task automatic test_loss();
      cur_test = "loss";
      step(gen, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      gen = tb_next(gen, taps);
      while (a5_soon(gen, taps)) begin
         step(gen, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
      for (int k = 0; k < 4; k++) begin
         step(8'hA5, 1'b1, 1'b0, (k < 3), 1'b1, (k == 3));
         gen = tb_next(gen, taps);
      end
      checks++;
      if (err_count !== 16'd4) begin
         failures++;
         $display("FAIL loss count got=%0d want=4", err_count);
      end
      cur_test = "relock";
      for (int i = 0; i < 5; i++) begin
         step(gen, 1'b1, 1'b0, (i >= 4), 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
   endtask

   task automatic test_enable_gap();
      cur_test = "enable_gap";
      for (int i = 0; i < 10; i++) begin
         step(8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         step(gen, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
   endtask

   task automatic test_taps_change();
      cur_test = "taps_change";
      taps = 8'b1011_1000;
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cur_test = "zero_lockup";
      for (int i = 0; i < 20; i++) begin
         step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      cur_test = "hunt_after_zero";
      gen = 8'h01;
      for (int i = 0; i < 5; i++) begin
         step(gen, 1'b1, 1'b0, (i >= 4), 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
   endtask

   task automatic test_clear_saturation();
      cur_test = "clear_vs_error";
      step(gen ^ 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      gen = tb_next(gen, taps);
      checks++;
      if (err_count !== 16'd0) begin
         failures++;
         $display("FAIL clear_vs_error count got=%0d want=0", err_count);
      end
      cur_test = "saturation";
      for (int k = 0; k < 5; k++) begin
         step(gen ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         gen = tb_next(gen, taps);
         step(gen, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         gen = tb_next(gen, taps);
      end
      checks++;
      if (err_count !== 16'd5 || s_err_count !== 2'd3) begin
         failures++;
         $display("FAIL saturation counts got=%0d/%0d want=5/3", err_count, s_err_count);
      end
   endtask

   task automatic test_reset_mid();
      cur_test = "reset_mid";
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({locked, err_pulse, lock_lost, err_count, s_locked, s_err_pulse, s_lock_lost,
           s_err_count} !== '0) begin
         failures++;
         $display("FAIL reset_mid outputs got=%b%b%b/%0d want=000/0", locked, err_pulse,
                  lock_lost, err_count);
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard leftover got=%0d want=0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_single_error();
      test_loss();
      test_enable_gap();
      test_taps_change();
      test_clear_saturation();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Self-synchronising sequence checker sitting directly downstream of `lfsr`. It consumes the `seq` word stream, qualified by the same `enable` that advances the generator. It locks onto the stream by predicting each next word from the previous one using the shared `taps`. Once locked, it flags and counts mismatches and drops lock after a run of consecutive errors. Used in the LFSR sandbox as the BIST receiver and as a link-integrity monitor.

## Interface
- `WIDTH`, 8, word width; must equal the `WIDTH` of the upstream `lfsr`
- `LOCK_COUNT`, 4, consecutive correct predictions required to declare lock (≥1)
- `LOSS_COUNT`, 4, consecutive mispredictions while locked that force loss of lock (≥1)
- `ERR_WIDTH`, 16, width of the error counter

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  `seq` is valid and consumed this cycle; when low, no state changes except via `clear`
- `taps`  in  WIDTH  feedback polynomial mask, same value as driven to `lfsr`
- `seq`  in  WIDTH  received sequence word
- `clear`  in  1  synchronous clear of `err_count`
- `locked`  out  1  checker is in LOCKED
- `err_pulse`  out  1  one-cycle flag for a mispredicted word while locked
- `err_count`  out  ERR_WIDTH  saturating count of mispredicted words while locked
- `lock_lost`  out  1  one-cycle flag on the LOCKED→HUNT transition

## Operation
- Next-word function, identical to `lfsr`: `next(s) = {s[WIDTH-2:0], ^(s & taps)}`.
- Registers: `pred` (WIDTH), `taps_q` (WIDTH), `match_cnt`, `miss_cnt`, state.
- **HUNT.** On an enabled word with `seq != 0`: `pred <= next(seq)`, `match_cnt <= 0`, go to SYNC. A zero word is ignored, because zero is the lock-up state.
- **SYNC.** On an enabled word:
  - If `seq == pred`: `match_cnt++` and `pred <= next(seq)`. If `match_cnt` reaches `LOCK_COUNT`, go to LOCKED with `miss_cnt <= 0`.
  - Otherwise, if `seq != 0`, re-seed: `pred <= next(seq)`, `match_cnt <= 0`, stay in SYNC.
  - A mismatching zero word returns to HUNT.
  - No errors are counted in HUNT or SYNC.
- **LOCKED.** On an enabled word, `pred <= next(pred)` (flywheel: the prediction never re-seeds from received data).
  - Match: `miss_cnt <= 0`.
  - Mismatch: `err_pulse = 1`, `err_count++` (saturating at all-ones), `miss_cnt++`.
  - When `miss_cnt` reaches `LOSS_COUNT`, go to HUNT and assert `lock_lost`.
- **Taps change.** `taps_q` samples `taps` every cycle. If `taps != taps_q`, the state is forced to HUNT with `match_cnt` and `miss_cnt` cleared. This overrides the `enable` word that cycle. `lock_lost` pulses if leaving LOCKED.
- **Clear.**
  - `clear` sets `err_count <= 0`.
  - `clear` wins over a simultaneous increment, and that cycle's error is not counted.
  - `err_pulse` still fires.
  - `clear` does not affect lock state.
- **Reset values:** state HUNT, `locked = 0`, `err_pulse = 0`, `lock_lost = 0`, `err_count = 0`, `pred = 0`, `match_cnt = 0`, `miss_cnt = 0`, `taps_q = 0`. The first cycle after reset with nonzero `taps` therefore forces HUNT, which is harmless.
- **Reset mid-operation:** immediately returns all registers to their reset values, asynchronously.

## Timing
- All outputs are registered.
- `err_pulse` is high for exactly the one cycle following the edge that sampled the bad word.
- `err_count` updates on that same edge.
- `locked` rises on the edge that samples the `LOCK_COUNT`-th consecutive correct word. With defaults, that is the 5th enabled word after entering HUNT: 1 seed word plus 4 matches.
- `locked` falls, and `lock_lost` pulses, on the edge that samples the `LOSS_COUNT`-th consecutive bad word.
- Gaps in `enable` are transparent: prediction and counters hold.
- Back-to-back enabled words at full clock rate are supported. Throughput is one word per cycle.

## Structure
- Shared package `lfsr_pkg` holds:
  - the state encoding localparams (HUNT, SYNC, LOCKED);
  - a `lfsr_next(s, taps)` function.
- `lfsr` and `lfsr_checker` both use `lfsr_next`, so the polynomial convention is defined once.
- No sub-module; a single FSM plus counters.

## Test plan
- **Acquire:** after reset, drive `lfsr` with `taps = 8'b10001110`, `enable = 1`, `seq` wired into the checker. `locked = 1` after the 5th enabled word; `err_count = 0` across all 255 words of the full period.
- **Single error:** while locked, XOR `seq` with `8'h01` for one word. Expect exactly one `err_pulse`, `err_count = 1`, `locked` stays 1, and the next correct word yields no error (flywheel).
- **Loss:** while locked, force `seq = 8'hA5` constant for 4 words. Expect `err_count = 4`, `lock_lost` pulsed once, `locked = 0`. After restoring the true stream, re-lock after 5 words.
- **Enable gap:** while locked, hold `enable = 0` for 10 cycles with random `seq`. Expect no `err_pulse`, and `locked` stays 1. Resuming the stream gives zero errors.
- **Taps change and zero lock-up:**
  - While locked, change `taps` to `8'b10111000`: `lock_lost` pulses and state is HUNT.
  - Drive `seq = 0` continuously: the checker never leaves HUNT.
- **Clear, saturation and reset:**
  - Simultaneous `clear` and error gives `err_count = 0`.
  - With `ERR_WIDTH = 2`, 5 errors give `err_count = 3`.
  - `rst_n` low mid-LOCKED drops all outputs to 0 immediately.
